// File: rtl/bin_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock, valid/ready on both sides.
// Define BIN_BCD_SEQ_SIGNED_EN for two's-complement input with a separate Sign output.
module bin_bcd_seq #(
  parameter int W  = 32,
  parameter int BW = W + (W - 4) / 3 + 1
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          In_Valid,
  output logic          In_Ready,
  input  logic [W-1:0]  Bin,
  output logic          Out_Valid,
  input  logic          Out_Ready,
  output logic [BW-1:0] Bcd,
  output logic          Busy
`ifdef BIN_BCD_SEQ_SIGNED_EN
  ,
  output logic          Sign
`endif
);

  localparam int ND   = (BW + 3) / 4;
  localparam int TOPW = BW - 4 * (ND - 1);
  localparam int CW   = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          r_state;
  logic [W-1:0]    r_sh;
  logic [BW-1:0]   r_acc;
  logic [BW-1:0]   r_bcd;
  logic [CW-1:0]   r_cnt;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;

  logic [BW-1:0]   w_adj;
  logic [BW-1:0]   w_acc_next;
  logic [W-1:0]    w_mag;

  // A truncated top digit never reaches 5 before the final shift, so it needs no correction.
  genvar gi;
  generate
    for (gi = 0; gi < ND; gi++) begin : g_digit
      if ((gi < ND - 1) || (TOPW == 4)) begin : g_full
        assign w_adj[4*gi +: 4] = (r_acc[4*gi +: 4] > 4'd4) ? (r_acc[4*gi +: 4] + 4'd3)
                                                            : r_acc[4*gi +: 4];
      end else begin : g_part
        assign w_adj[BW-1:4*gi] = r_acc[BW-1:4*gi];
      end
    end
  endgenerate

  assign w_acc_next = (w_adj << 1) | {{(BW-1){1'b0}}, r_sh[W-1]};

`ifdef BIN_BCD_SEQ_SIGNED_EN
  logic r_sign_pend;
  logic r_sign;
  assign w_mag = Bin[W-1] ? ((~Bin) + {{(W-1){1'b0}}, 1'b1}) : Bin;
  assign Sign  = r_sign;
`else
  assign w_mag = Bin;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state     <= IDLE;
      r_sh        <= '0;
      r_acc       <= '0;
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef BIN_BCD_SEQ_SIGNED_EN
      r_sign_pend <= 1'b0;
      r_sign      <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (In_Valid) begin
            r_sh       <= w_mag;
            r_acc      <= '0;
            r_cnt      <= CW'(W);
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= SHIFT;
`ifdef BIN_BCD_SEQ_SIGNED_EN
            r_sign_pend <= Bin[W-1];
`endif
          end
        end
        SHIFT: begin
          r_acc <= w_acc_next;
          r_sh  <= r_sh << 1;
          r_cnt <= r_cnt - CW'(1);
          // Final shift: the result lands in Bcd on the same edge that enters DONE.
          if (r_cnt == CW'(1)) begin
            r_bcd       <= w_acc_next;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
`ifdef BIN_BCD_SEQ_SIGNED_EN
            r_sign      <= r_sign_pend;
`endif
          end
        end
        DONE: begin
          if (Out_Ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign In_Ready  = r_in_ready;
  assign Out_Valid = r_out_valid;
  assign Busy      = r_busy;
  assign Bcd       = r_bcd;

endmodule
